// File: rtl/multicycle_sequencer_if.sv
// Instruction/data memory handshake bundle between the multi-cycle sequencer
// and the memory ports.
interface multicycle_sequencer_if;
    logic imem_req;
    logic imem_ready;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ready;

    modport master (
        output imem_req, dmem_req, dmem_we,
        input  imem_ready, dmem_ready
    );

    modport slave (
        input  imem_req, dmem_req, dmem_we,
        output imem_ready, dmem_ready
    );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle rv32i control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared datapath, with sticky trap flags and a retired-instruction counter.
module multicycle_sequencer #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    multicycle_sequencer_if.master mem,
    input  logic [6:0]             opcode,
    input  logic                   branch_taken,
    output logic                   ir_en,
    output logic                   pc_en,
    output logic [1:0]             pc_sel,
    output logic                   we,
    output logic [1:0]             alu_op,
    output logic                   op_b_sel,
    output logic [1:0]             wb_sel,
    output logic                   illegal,
    output logic                   bus_err,
    output logic [CNT_W-1:0]       instret,
    output logic [2:0]             state
);
    localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_TRAP      = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        C_NONE, C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL
    } class_e;

    state_e           state_q, state_d;
    class_e           cls_q, cls_d;
    logic             illegal_q, illegal_d;
    logic             bus_err_q, bus_err_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic [WAIT_W-1:0] wait_q, wait_d;

    logic       retire;
    logic       imem_req_c, dmem_req_c, dmem_we_c, ir_en_c, pc_en_c, we_c, op_b_sel_c;
    logic [1:0] pc_sel_c, alu_op_c, wb_sel_c;

    always_comb begin
        state_d    = state_q;
        cls_d      = cls_q;
        illegal_d  = illegal_q;
        bus_err_d  = bus_err_q;
        instret_d  = instret_q;
        wait_d     = '0;
        retire     = 1'b0;
        imem_req_c = 1'b0;
        dmem_req_c = 1'b0;
        dmem_we_c  = 1'b0;
        ir_en_c    = 1'b0;
        pc_en_c    = 1'b0;
        we_c       = 1'b0;
        op_b_sel_c = 1'b0;
        pc_sel_c   = 2'd0;
        alu_op_c   = 2'b00;
        wb_sel_c   = 2'd0;

        case (state_q)
            S_FETCH: begin
                imem_req_c = 1'b1;
                if (mem.imem_ready) begin
                    ir_en_c = 1'b1;
                    state_d = S_DECODE;
                end else if (wait_q == WAIT_LIM) begin
                    bus_err_d = 1'b1;
                    state_d   = S_TRAP;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_DECODE: begin
                state_d = S_EXECUTE;
                case (opcode)
                    7'b0110011: cls_d = C_R;
                    7'b0010011: cls_d = C_I;
                    7'b0000011: cls_d = C_LOAD;
                    7'b0100011: cls_d = C_STORE;
                    7'b1100011: cls_d = C_BRANCH;
                    7'b1101111: cls_d = C_JAL;
                    default: begin
                        cls_d     = C_NONE;
                        illegal_d = 1'b1;
                        state_d   = S_TRAP;
                    end
                endcase
            end
            S_EXECUTE: begin
                case (cls_q)
                    C_R: begin
                        alu_op_c = 2'b10;
                        state_d  = S_WRITEBACK;
                    end
                    C_I: begin
                        alu_op_c   = 2'b10;
                        op_b_sel_c = 1'b1;
                        state_d    = S_WRITEBACK;
                    end
                    C_LOAD, C_STORE: begin
                        op_b_sel_c = 1'b1;
                        state_d    = S_MEMORY;
                    end
                    C_BRANCH: begin
                        alu_op_c = 2'b01;
                        pc_en_c  = 1'b1;
                        pc_sel_c = branch_taken ? 2'd1 : 2'd0;
                        retire   = 1'b1;
                        state_d  = S_FETCH;
                    end
                    C_JAL:   state_d = S_WRITEBACK;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMORY: begin
                // Address generation stays selected for the whole access.
                op_b_sel_c = 1'b1;
                dmem_req_c = 1'b1;
                dmem_we_c  = (cls_q == C_STORE);
                if (mem.dmem_ready) begin
                    if (cls_q == C_STORE) begin
                        pc_en_c = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WRITEBACK;
                    end
                end else if (wait_q == WAIT_LIM) begin
                    bus_err_d = 1'b1;
                    state_d   = S_TRAP;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_WRITEBACK: begin
                we_c     = 1'b1;
                pc_en_c  = 1'b1;
                retire   = 1'b1;
                wb_sel_c = (cls_q == C_LOAD) ? 2'd1 : (cls_q == C_JAL) ? 2'd2 : 2'd0;
                pc_sel_c = (cls_q == C_JAL) ? 2'd2 : 2'd0;
                state_d  = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase

        if (retire) instret_d = instret_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            cls_q     <= C_NONE;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
            instret_q <= '0;
            wait_q    <= '0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
            instret_q <= instret_d;
            wait_q    <= wait_d;
        end
    end

    // Strobes are squashed while reset is held so an aborted instruction leaves no side effects.
    assign mem.imem_req = imem_req_c & ~rst;
    assign mem.dmem_req = dmem_req_c & ~rst;
    assign mem.dmem_we  = dmem_we_c  & ~rst;
    assign ir_en        = ir_en_c    & ~rst;
    assign pc_en        = pc_en_c    & ~rst;
    assign we           = we_c       & ~rst;
    assign op_b_sel     = op_b_sel_c & ~rst;
    assign pc_sel       = rst ? 2'd0 : pc_sel_c;
    assign alu_op       = rst ? 2'd0 : alu_op_c;
    assign wb_sel       = rst ? 2'd0 : wb_sel_c;
    assign illegal      = illegal_q;
    assign bus_err      = bus_err_q;
    assign instret      = instret_q;
    assign state        = state_q;
endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed self-checking bench for multicycle_sequencer.
module tb_multicycle_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  opcode;
    logic        branch_taken;
    logic        ir_en, pc_en, we, op_b_sel, illegal, bus_err;
    logic [1:0]  pc_sel, alu_op, wb_sel;
    logic [31:0] instret;
    logic [2:0]  state;
    int          n_chk = 0;
    int          n_pass = 0;
    int          n_req;

    multicycle_sequencer_if mif ();

    multicycle_sequencer #(.CNT_W(32), .MEM_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .mem(mif.master), .opcode(opcode),
        .branch_taken(branch_taken), .ir_en(ir_en), .pc_en(pc_en),
        .pc_sel(pc_sel), .we(we), .alu_op(alu_op), .op_b_sel(op_b_sel),
        .wb_sel(wb_sel), .illegal(illegal), .bus_err(bus_err),
        .instret(instret), .state(state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        rst = 1'b1; opcode = 7'b0110011; branch_taken = 1'b0;
        mif.imem_ready = 1'b1; mif.dmem_ready = 1'b0;
        tick(); tick();
        chk("rst_state", 32'(state), 0);
        chk("rst_imem_req", 32'(mif.imem_req), 0);
        chk("rst_ir_en", 32'(ir_en), 0);
        chk("rst_instret", instret, 0);
        chk("rst_flags", {30'd0, illegal, bus_err}, 0);

        // R-type, zero-wait fetch
        rst = 1'b0; #1;
        chk("r_fetch_state", 32'(state), 0);
        chk("r_fetch_req", 32'(mif.imem_req), 1);
        chk("r_fetch_ir_en", 32'(ir_en), 1);
        tick();
        chk("r_dec_state", 32'(state), 1);
        chk("r_dec_strobes", {28'd0, mif.imem_req, ir_en, we, pc_en}, 0);
        tick();
        chk("r_ex_state", 32'(state), 2);
        chk("r_ex_alu_op", 32'(alu_op), 2);
        chk("r_ex_op_b", 32'(op_b_sel), 0);
        chk("r_ex_we_pc", {30'd0, we, pc_en}, 0);
        tick();
        chk("r_wb_state", 32'(state), 4);
        chk("r_wb_we_pc", {30'd0, we, pc_en}, 3);
        chk("r_wb_sel", 32'(wb_sel), 0);
        tick();
        chk("r_done_state", 32'(state), 0);
        chk("r_instret", instret, 1);

        // LOAD with dmem_ready on the 4th MEMORY cycle: 8 cycles total
        opcode = 7'b0000011;
        tick();
        chk("ld_dec_state", 32'(state), 1);
        tick();
        chk("ld_ex_alu", {29'd0, alu_op, op_b_sel}, 1);
        chk("ld_ex_dreq", 32'(mif.dmem_req), 0);
        n_req = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 3) mif.dmem_ready = 1'b1;
            #1;
            chk("ld_mem_state", 32'(state), 3);
            chk("ld_mem_we", 32'(mif.dmem_we), 0);
            if (mif.dmem_req) n_req++;
        end
        chk("ld_req_cycles", 32'(n_req), 4);
        tick();
        mif.dmem_ready = 1'b0;
        chk("ld_wb_state", 32'(state), 4);
        chk("ld_wb_sel", 32'(wb_sel), 1);
        chk("ld_wb_we_pc", {30'd0, we, pc_en}, 3);
        chk("ld_wb_dreq", 32'(mif.dmem_req), 0);
        tick();
        chk("ld_done_state", 32'(state), 0);
        chk("ld_instret", instret, 2);

        // STORE then taken BRANCH back to back
        opcode = 7'b0100011; mif.dmem_ready = 1'b1;
        tick();
        chk("st_dec_we", 32'(we), 0);
        tick();
        chk("st_ex", {28'd0, alu_op, op_b_sel, we}, 32'b0010);
        tick();
        chk("st_mem_state", 32'(state), 3);
        chk("st_mem_req_we", {30'd0, mif.dmem_req, mif.dmem_we}, 3);
        chk("st_mem_pc", {28'd0, pc_en, pc_sel, we}, 32'b1000);
        tick();
        chk("st_done_state", 32'(state), 0);
        chk("st_instret", instret, 3);
        opcode = 7'b1100011; branch_taken = 1'b1; mif.dmem_ready = 1'b0;
        tick();
        tick();
        #1;
        chk("br_ex_state", 32'(state), 2);
        chk("br_ex_pc", {29'd0, pc_en, pc_sel}, 32'b101);
        chk("br_ex_alu", {29'd0, alu_op, op_b_sel}, 32'b010);
        chk("br_ex_we", 32'(we), 0);
        tick();
        chk("br_done_state", 32'(state), 0);
        chk("br_instret", instret, 4);
        branch_taken = 1'b0;

        // Illegal opcode traps and stays trapped until reset
        opcode = 7'b1111111;
        tick();
        chk("ill_dec_state", 32'(state), 1);
        tick();
        chk("ill_trap_state", 32'(state), 5);
        chk("ill_flag", 32'(illegal), 1);
        tick(); tick();
        chk("ill_trap_hold", 32'(state), 5);
        chk("ill_no_ireq", 32'(mif.imem_req), 0);
        chk("ill_instret", instret, 4);
        rst = 1'b1;
        tick();
        chk("ill_rst_state", 32'(state), 0);
        chk("ill_rst_flag", 32'(illegal), 0);
        chk("ill_rst_instret", instret, 0);
        rst = 1'b0; #1;
        chk("ill_resume_req", 32'(mif.imem_req), 1);

        // Fetch timeout: 16 cycles with imem_ready low
        mif.imem_ready = 1'b0; opcode = 7'b0110011;
        for (int i = 1; i <= 16; i++) begin
            chk("to_wait_state", 32'(state), 0);
            chk("to_wait_err", 32'(bus_err), 0);
            tick();
        end
        chk("to_trap_state", 32'(state), 5);
        chk("to_bus_err", 32'(bus_err), 1);
        chk("to_trap_ireq", 32'(mif.imem_req), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("to_rst_err", 32'(bus_err), 0);
        for (int i = 1; i <= 15; i++) tick();
        mif.imem_ready = 1'b1; #1;
        chk("to_last_state", 32'(state), 0);
        chk("to_last_ir_en", 32'(ir_en), 1);
        tick();
        chk("to_ready_state", 32'(state), 1);
        chk("to_ready_err", 32'(bus_err), 0);
        tick(); tick(); tick();
        chk("to_r_instret", instret, 1);

        // Reset during MEMORY of a LOAD aborts without retiring
        opcode = 7'b0000011; mif.dmem_ready = 1'b0;
        tick(); tick(); tick();
        chk("rm_mem_state", 32'(state), 3);
        chk("rm_mem_req", 32'(mif.dmem_req), 1);
        rst = 1'b1; #1;
        chk("rm_rst_req", 32'(mif.dmem_req), 0);
        tick();
        chk("rm_state", 32'(state), 0);
        chk("rm_instret", instret, 0);
        chk("rm_we_pc", {30'd0, we, pc_en}, 0);
        rst = 1'b0; #1;
        chk("rm_fetch_dreq", 32'(mif.dmem_req), 0);
        chk("rm_fetch_ireq", 32'(mif.imem_req), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
